// File: rtl/hack_sequencer.sv
// rtl/hack_sequencer.sv - Multi-cycle Hack CPU control unit with A/D/PC registers and ALU
//
// hack_alu       : combinational Hack ALU (x, y, zx/nx/zy/ny/f/no -> out, zr, ng)
// hack_sequencer : FETCH/DECODE/LOAD/EXEC/STORE sequencer
//   i_clk, i_reset                                   clock, async active-high reset
//   o_imem_req, o_imem_addr, i_imem_rdata, i_imem_ack instruction fetch handshake
//   o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wdata,
//   i_dmem_rdata, i_dmem_ack                         data memory handshake
//   o_pc, o_a_out, o_d_out                           committed PC, A and D
//   o_instr_done                                     one-cycle pulse after each commit

module hack_alu (
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic        i_zx,
   input  logic        i_nx,
   input  logic        i_zy,
   input  logic        i_ny,
   input  logic        i_f,
   input  logic        i_no,
   output logic [15:0] o_out,
   output logic        o_zr,
   output logic        o_ng
);
   logic [15:0] w_x;
   logic [15:0] w_y;
   logic [15:0] w_f;

   always_comb begin
      w_x = i_zx ? 16'h0000 : i_x;
      if (i_nx) w_x = ~w_x;
      w_y = i_zy ? 16'h0000 : i_y;
      if (i_ny) w_y = ~w_y;
      w_f = i_f ? (w_x + w_y) : (w_x & w_y);
   end

   assign o_out = i_no ? ~w_f : w_f;
   assign o_zr  = (o_out == 16'h0000);
   assign o_ng  = o_out[15];
endmodule

module hack_sequencer (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic        o_imem_req,
   output logic [14:0] o_imem_addr,
   input  logic [15:0] i_imem_rdata,
   input  logic        i_imem_ack,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [14:0] o_dmem_addr,
   output logic [15:0] o_dmem_wdata,
   input  logic [15:0] i_dmem_rdata,
   input  logic        i_dmem_ack,
   output logic [14:0] o_pc,
   output logic [15:0] o_a_out,
   output logic [15:0] o_d_out,
   output logic        o_instr_done
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_LOAD   = 3'd2,
      S_EXEC   = 3'd3,
      S_STORE  = 3'd4
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [14:0] r_pc;
   logic [15:0] r_a;
   logic [15:0] r_d;
   logic [15:0] r_ir;
   logic [15:0] r_mbuf;
   logic [15:0] r_res;
   logic        r_zr;
   logic        r_ng;
   logic        r_done;

   logic [15:0] w_alu_y;
   logic [15:0] w_alu_out;
   logic        w_alu_zr;
   logic        w_alu_ng;
   logic        w_commit;
   logic [15:0] w_cres;
   logic        w_czr;
   logic        w_cng;
   logic        w_jmp;
   logic [14:0] w_pc_inc;

   assign w_alu_y = r_ir[12] ? r_mbuf : r_a;

   hack_alu u_alu (
      .i_x   (r_d),
      .i_y   (w_alu_y),
      .i_zx  (r_ir[11]),
      .i_nx  (r_ir[10]),
      .i_zy  (r_ir[9]),
      .i_ny  (r_ir[8]),
      .i_f   (r_ir[7]),
      .i_no  (r_ir[6]),
      .o_out (w_alu_out),
      .o_zr  (w_alu_zr),
      .o_ng  (w_alu_ng)
   );

   // Commit source: live ALU result when committing straight from EXEC,
   // otherwise the values latched in EXEC (STORE path).
   always_comb begin
      w_state_nxt = r_state;
      w_commit    = 1'b0;
      w_cres      = r_res;
      w_czr       = r_zr;
      w_cng       = r_ng;
      case (r_state)
         S_FETCH: begin
            if (i_imem_ack) w_state_nxt = S_DECODE;
         end
         S_DECODE: begin
            if (!r_ir[15]) begin
               w_commit    = 1'b1;
               w_state_nxt = S_FETCH;
            end else if (r_ir[12]) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_state_nxt = S_EXEC;
            end
         end
         S_LOAD: begin
            if (i_dmem_ack) w_state_nxt = S_EXEC;
         end
         S_EXEC: begin
            if (r_ir[3]) begin
               w_state_nxt = S_STORE;
            end else begin
               w_commit    = 1'b1;
               w_cres      = w_alu_out;
               w_czr       = w_alu_zr;
               w_cng       = w_alu_ng;
               w_state_nxt = S_FETCH;
            end
         end
         S_STORE: begin
            if (i_dmem_ack) begin
               w_commit    = 1'b1;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end

   assign w_jmp    = (r_ir[2] & w_cng) | (r_ir[1] & w_czr) | (r_ir[0] & ~w_czr & ~w_cng);
   assign w_pc_inc = r_pc + 15'd1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= S_FETCH;
         r_pc    <= 15'd0;
         r_a     <= 16'd0;
         r_d     <= 16'd0;
         r_ir    <= 16'd0;
         r_mbuf  <= 16'd0;
         r_res   <= 16'd0;
         r_zr    <= 1'b0;
         r_ng    <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_commit;
         if (r_state == S_FETCH && i_imem_ack) r_ir <= i_imem_rdata;
         if (r_state == S_LOAD && i_dmem_ack) r_mbuf <= i_dmem_rdata;
         if (r_state == S_EXEC) begin
            r_res <= w_alu_out;
            r_zr  <= w_alu_zr;
            r_ng  <= w_alu_ng;
         end
         if (w_commit) begin
            if (!r_ir[15]) begin
               r_a  <= {1'b0, r_ir[14:0]};
               r_pc <= w_pc_inc;
            end else begin
               // r_a on the right-hand side is still the pre-write A.
               if (r_ir[5]) r_a <= w_cres;
               if (r_ir[4]) r_d <= w_cres;
               r_pc <= w_jmp ? r_a[14:0] : w_pc_inc;
            end
         end
      end
   end

   // Requests are gated by reset so they drop in the same cycle reset rises.
   assign o_imem_req   = (r_state == S_FETCH) & ~i_reset;
   assign o_imem_addr  = r_pc;
   assign o_dmem_req   = ((r_state == S_LOAD) | (r_state == S_STORE)) & ~i_reset;
   assign o_dmem_we    = (r_state == S_STORE);
   assign o_dmem_addr  = r_a[14:0];
   assign o_dmem_wdata = r_res;
   assign o_pc         = r_pc;
   assign o_a_out      = r_a;
   assign o_d_out      = r_d;
   assign o_instr_done = r_done;
endmodule

// File: tb/tb_hack_sequencer.sv
// tb/tb_hack_sequencer.sv - Randomized self-checking bench for hack_sequencer against an ISA-level model
module tb_hack_sequencer;
   logic        i_clk = 1'b0;
   logic        i_reset;
   logic        o_imem_req;
   logic [14:0] o_imem_addr;
   logic [15:0] i_imem_rdata;
   logic        i_imem_ack;
   logic        o_dmem_req;
   logic        o_dmem_we;
   logic [14:0] o_dmem_addr;
   logic [15:0] o_dmem_wdata;
   logic [15:0] i_dmem_rdata;
   logic        i_dmem_ack;
   logic [14:0] o_pc;
   logic [15:0] o_a_out;
   logic [15:0] o_d_out;
   logic        o_instr_done;

   hack_sequencer dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .o_imem_req   (o_imem_req),
      .o_imem_addr  (o_imem_addr),
      .i_imem_rdata (i_imem_rdata),
      .i_imem_ack   (i_imem_ack),
      .o_dmem_req   (o_dmem_req),
      .o_dmem_we    (o_dmem_we),
      .o_dmem_addr  (o_dmem_addr),
      .o_dmem_wdata (o_dmem_wdata),
      .i_dmem_rdata (i_dmem_rdata),
      .i_dmem_ack   (i_dmem_ack),
      .o_pc         (o_pc),
      .o_a_out      (o_a_out),
      .o_d_out      (o_d_out),
      .o_instr_done (o_instr_done)
   );

   always #5 i_clk = ~i_clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Architectural model: PC, A, D and the whole data RAM.
   logic [14:0] m_pc;
   logic [15:0] m_a;
   logic [15:0] m_d;
   logic [15:0] m_ram [0:32767];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
      logic [15:0] xx, yy, r;
      xx = c[5] ? 16'h0000 : x;
      if (c[4]) xx = ~xx;
      yy = c[3] ? 16'h0000 : y;
      if (c[2]) yy = ~yy;
      r = c[1] ? 16'(xx + yy) : (xx & yy);
      if (c[0]) r = ~r;
      return r;
   endfunction

   // Starts at a negedge while the DUT should be fetching; returns at the
   // negedge after the accepting edge.
   task automatic fetch(input logic [15:0] instr, input int wf, inout int n_cyc);
      for (int k = 0; k <= wf; k++) begin
         chk("imem_req", o_imem_req, 1);
         chk("imem_addr", o_imem_addr, m_pc);
         if (k > 0) chk("done_pulse", o_instr_done, 0);
         i_imem_ack   = (k == wf);
         i_imem_rdata = (k == wf) ? instr : 16'($urandom);
         if (!o_dmem_req) begin
            i_dmem_ack   = 1'($urandom);
            i_dmem_rdata = 16'($urandom);
         end
         @(posedge i_clk);
         @(negedge i_clk);
         n_cyc++;
      end
      i_imem_ack = 1'b0;
   endtask

   // Runs one instruction with the given fetch/read/write ack delays and
   // checks protocol, latency and resulting architectural state.
   task automatic exec(input logic [15:0] instr, input int wf, input int wr, input int ww);
      logic        is_c, rd, wm, jmp;
      logic [14:0] addr;
      logic [15:0] y, res, a_old;
      int          n_cyc, n_rd, n_wr, exp_cyc;
      bit          done;
      is_c  = instr[15];
      rd    = is_c & instr[12];
      wm    = is_c & instr[3];
      addr  = m_a[14:0];
      y     = rd ? m_ram[addr] : m_a;
      res   = alu_ref(m_d, y, instr[11:6]);
      n_cyc = 0;
      n_rd  = 0;
      n_wr  = 0;
      done  = 0;
      fetch(instr, wf, n_cyc);
      while (!done && n_cyc < 40) begin
         if (o_instr_done) begin
            done = 1;
         end else begin
            if (o_dmem_req) begin
               chk("dmem_addr", o_dmem_addr, addr);
               if (o_dmem_we) begin
                  chk("dmem_wdata", o_dmem_wdata, res);
                  i_dmem_ack = (n_wr == ww);
                  n_wr++;
               end else begin
                  i_dmem_ack   = (n_rd == wr);
                  i_dmem_rdata = i_dmem_ack ? m_ram[addr] : 16'($urandom);
                  n_rd++;
               end
            end else begin
               i_dmem_ack   = 1'($urandom);
               i_dmem_rdata = 16'($urandom);
            end
            i_imem_ack   = o_imem_req ? 1'b0 : 1'($urandom);
            i_imem_rdata = 16'($urandom);
            @(posedge i_clk);
            @(negedge i_clk);
            n_cyc++;
         end
      end
      i_dmem_ack = 1'b0;
      i_imem_ack = 1'b0;
      exp_cyc = (is_c ? 3 + int'(rd) + int'(wm) : 2) + wf + (rd ? wr : 0) + (wm ? ww : 0);
      chk("instr_done_seen", done, 1);
      chk("cycles", n_cyc, exp_cyc);
      chk("read_cycles", n_rd, rd ? wr + 1 : 0);
      chk("write_cycles", n_wr, wm ? ww + 1 : 0);
      if (!is_c) begin
         m_a  = {1'b0, instr[14:0]};
         m_pc = m_pc + 15'd1;
      end else begin
         if (wm) m_ram[addr] = res;
         a_old = m_a;
         if (instr[5]) m_a = res;
         if (instr[4]) m_d = res;
         jmp = (instr[2] && $signed(res) < 0) || (instr[1] && res == 0) ||
               (instr[0] && $signed(res) > 0);
         m_pc = jmp ? a_old[14:0] : m_pc + 15'd1;
      end
      chk("pc", o_pc, m_pc);
      chk("a", o_a_out, m_a);
      chk("d", o_d_out, m_d);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [15:0] instr;
      i_reset      = 1'b1;
      i_imem_ack   = 1'b0;
      i_imem_rdata = 16'h0;
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = 16'h0;
      for (int i = 0; i < 32768; i++) m_ram[i] = 16'($urandom);
      m_pc = 15'd0;
      m_a  = 16'd0;
      m_d  = 16'd0;

      repeat (3) begin
         @(negedge i_clk);
         chk("rst_imem_req", o_imem_req, 0);
         chk("rst_dmem_req", o_dmem_req, 0);
         chk("rst_pc", o_pc, 0);
         chk("rst_a", o_a_out, 0);
         chk("rst_d", o_d_out, 0);
         chk("rst_done", o_instr_done, 0);
      end
      i_reset = 1'b0;
      #1;
      chk("post_rst_imem_req", o_imem_req, 1);
      chk("post_rst_imem_addr", o_imem_addr, 0);

      // A- and C-instruction timing: @5, D=A
      exec(16'h0005, 0, 0, 0);
      exec(16'hEC10, 0, 0, 0);
      chk("scn2_a", o_a_out, 16'd5);
      chk("scn2_d", o_d_out, 16'd5);
      chk("scn2_pc", o_pc, 15'd2);
      // M=D+1 with write ack delayed 3 cycles
      exec(16'hE7C8, 0, 0, 3);
      chk("scn3_d", o_d_out, 16'd5);
      // D=M with M=0x1234
      m_ram[5] = 16'h1234;
      exec(16'hFC10, 0, 0, 0);
      chk("scn4_d", o_d_out, 16'h1234);
      // M=M+1 (read and write), with waits everywhere
      exec(16'hFDC8, 2, 1, 2);
      // @10; 0;JMP
      exec(16'h000A, 1, 0, 0);
      exec(16'hEA87, 0, 0, 0);
      chk("scn5_jmp_pc", o_pc, 15'd10);
      // D=0x8000, @20, D;JGT -> no jump
      exec(16'h7FFF, 0, 0, 0);
      exec(16'hEDD0, 0, 0, 0);
      chk("scn5_d8000", o_d_out, 16'h8000);
      exec(16'h0014, 0, 0, 0);
      exec(16'hE301, 0, 0, 0);
      // jump to 0x7FFF, then an A-instruction wraps PC to 0
      exec(16'h7FFF, 0, 0, 0);
      exec(16'hEA87, 0, 0, 0);
      chk("scn5_pc_max", o_pc, 15'h7FFF);
      exec(16'h0001, 0, 0, 0);
      chk("scn5_pc_wrap", o_pc, 15'd0);

      for (int t = 0; t < 150; t++) begin
         instr = 16'($urandom);
         if ($urandom_range(0, 1) == 1) instr[15] = 1'b0;
         exec(instr, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Reset while STORE waits for its ack
      exec(16'h0005, 0, 0, 0);
      n = 0;
      fetch(16'hE7C8, 0, n);
      i_dmem_ack = 1'b0;
      n = 0;
      while (!(o_dmem_req && o_dmem_we) && n < 10) begin
         @(posedge i_clk);
         @(negedge i_clk);
         n++;
      end
      chk("store_reached", o_dmem_req & o_dmem_we, 1);
      @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
      #1;
      chk("mid_rst_dmem_req", o_dmem_req, 0);
      chk("mid_rst_pc", o_pc, 0);
      chk("mid_rst_a", o_a_out, 0);
      chk("mid_rst_d", o_d_out, 0);
      chk("mid_rst_done", o_instr_done, 0);
      repeat (2) begin
         @(negedge i_clk);
         chk("mid_rst_done_hold", o_instr_done, 0);
         chk("mid_rst_imem_req", o_imem_req, 0);
         chk("mid_rst_dmem_req_hold", o_dmem_req, 0);
      end
      i_reset = 1'b0;
      #1;
      m_pc = 15'd0;
      m_a  = 16'd0;
      m_d  = 16'd0;
      chk("restart_imem_req", o_imem_req, 1);
      chk("restart_imem_addr", o_imem_addr, 0);
      chk("restart_done", o_instr_done, 0);
      exec(16'h0003, 0, 0, 0);
      exec(16'hEC10, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
